// File: rtl/memory_access_stage.sv
// Memory access (M) pipeline stage: issues one word access at a time to a
// request/acknowledge memory port, stalls upstream while it is outstanding,
// and registers the result into the W stage. Misaligned accesses never reach
// memory; they retire immediately as an exception.
module memory_access_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        validM,
   input  logic [31:0] PCM,
   input  logic [3:0]  rdM,
   input  logic [31:0] aluResultM,
   input  logic [31:0] op2M,
   input  logic        isLdM,
   input  logic        isStM,
   input  logic        isWbM,
   input  logic        isCallM,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        stallM,
   output logic        validW,
   output logic [31:0] PCW,
   output logic [3:0]  rdW,
   output logic [31:0] aluResultW,
   output logic [31:0] ldResultW,
   output logic        isLdW,
   output logic        isWbW,
   output logic        isCallW,
   output logic        excW
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        validW_q;
   logic [31:0] PCW_q;
   logic [3:0]  rdW_q;
   logic [31:0] aluResultW_q;
   logic [31:0] ldResultW_q;
   logic        isLdW_q;
   logic        isWbW_q;
   logic        isCallW_q;
   logic        excW_q;

   logic memop;
   logic aligned;
   logic issue;

   assign memop   = validM & (isLdM | isStM);
   assign aligned = (aluResultM[1:0] == 2'b00);
   assign issue   = (state_q == IDLE) & memop & aligned;

   assign stallM  = issue | ((state_q == BUSY) & ~mem_ack);
   assign mem_req = (state_q == BUSY);

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign validW     = validW_q;
   assign PCW        = PCW_q;
   assign rdW        = rdW_q;
   assign aluResultW = aluResultW_q;
   assign ldResultW  = ldResultW_q;
   assign isLdW      = isLdW_q;
   assign isWbW      = isWbW_q;
   assign isCallW    = isCallW_q;
   assign excW       = excW_q;

   // Access FSM, memory request registers and W-stage pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         validW_q     <= 1'b0;
         PCW_q        <= '0;
         rdW_q        <= '0;
         aluResultW_q <= '0;
         ldResultW_q  <= '0;
         isLdW_q      <= 1'b0;
         isWbW_q      <= 1'b0;
         isCallW_q    <= 1'b0;
         excW_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue) begin
                  state_q     <= BUSY;
                  mem_addr_q  <= aluResultM;
                  mem_wdata_q <= op2M;
                  mem_we_q    <= isStM;
                  validW_q    <= 1'b0;
               end else begin
                  // Pass-through and misaligned-exception retire share one
                  // path: a memop here is necessarily misaligned.
                  validW_q     <= validM;
                  PCW_q        <= PCM;
                  rdW_q        <= rdM;
                  aluResultW_q <= aluResultM;
                  isLdW_q      <= isLdM;
                  isCallW_q    <= isCallM;
                  isWbW_q      <= isWbM & ~memop;
                  excW_q       <= memop;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state_q      <= IDLE;
                  validW_q     <= 1'b1;
                  excW_q       <= 1'b0;
                  PCW_q        <= PCM;
                  rdW_q        <= rdM;
                  aluResultW_q <= aluResultM;
                  isLdW_q      <= isLdM;
                  isWbW_q      <= isWbM;
                  isCallW_q    <= isCallM;
                  if (isLdM & ~isStM) ldResultW_q <= mem_rdata;
               end else begin
                  validW_q <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset; clock clk.
REQ-002 SHALL have M-stage inputs: validM  in  1  instruction present; PCM  in  32  PC; rdM  in  4  dest reg; aluResultM  in  32  address/ALU result; op2M  in  32  store data; isLdM, isStM, isWbM, isCallM  in  1 each  control flags.
REQ-003 SHALL have memory inputs: mem_ack  in  1  access complete; mem_rdata  in  32  load data.
REQ-004 SHALL have memory outputs: mem_req  out  1  request active; mem_we  out  1  write enable; mem_addr  out  32  word address; mem_wdata  out  32  write data.
REQ-005 SHALL have stallM  out  1  to upstream: hold M-stage inputs.
REQ-006 SHALL have W outputs (registered): validW  1; PCW  32; rdW  4; aluResultW  32; ldResultW  32; isLdW, isWbW, isCallW  1 each; excW  1  misaligned access.

Function
REQ-007 memop = validM & (isLdM | isStM); aligned = (aluResultM[1:0] == 2'b00).
REQ-008 FSM states: IDLE, BUSY; SHALL be the only states.
REQ-009 IDLE, memop & aligned: next state BUSY; capture mem_addr=aluResultM, mem_wdata=op2M, mem_we=isStM into registers.
REQ-010 IDLE, otherwise: stay IDLE.
REQ-011 BUSY, mem_ack=1: next state IDLE; BUSY, mem_ack=0: stay BUSY.
REQ-012 mem_req SHALL equal (state==BUSY); mem_addr/mem_wdata/mem_we SHALL stay stable throughout BUSY.
REQ-013 stallM combinational: 1 if (IDLE & memop & aligned) or (BUSY & !mem_ack); else 0.
REQ-014 mem_ack while IDLE SHALL be ignored (no state/output change).
REQ-015 W update, non-memop or invalid M (IDLE): at each edge, validW<=validM, PCW/rdW/aluResultW/isWbW/isCallW/isLdW<=M values, excW<=0, ldResultW holds.
REQ-016 W update, misaligned memop (IDLE): validW<=1, excW<=1, isWbW<=0, no request issued, no stall; other fields pass through.
REQ-017 W update, IDLE with aligned memop: validW<=0 (bubble).
REQ-018 W update, BUSY & !mem_ack: validW<=0, other W fields hold.
REQ-019 W update, BUSY & mem_ack: validW<=1, excW<=0, M fields captured; ldResultW<=mem_rdata if isLdM, else holds.
REQ-020 Minimum memop latency: 2 cycles from M presentation to validW (ack in first BUSY cycle); each extra ack-less cycle adds 1.
REQ-021 Non-memop latency: 1 cycle, no stall, back-to-back throughput 1/cycle.
REQ-022 Upstream holds M inputs stable while stallM=1; block SHALL use live M values on the ack edge.
REQ-023 Load and store flags both set: treated as store (mem_we=1), ldResultW holds.

Reset
REQ-024 reset=1 asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all W outputs 0.
REQ-025 Reset during BUSY SHALL drop mem_req immediately, abandon access, no validW issued for it.
REQ-026 After deassert, first edge SHALL process M inputs per REQ-009/010.

Verification
REQ-027 ALU op validM=1, isWbM=1, rdM=3, aluResultM=0x10 -> next cycle validW=1, rdW=3, aluResultW=0x10, stallM=0 throughout.
REQ-028 Load aluResultM=0x100, ack after 3 BUSY cycles, mem_rdata=0xDEADBEEF -> mem_req high 3 cycles, addr 0x100, we=0, stallM high 3 cycles, then validW=1, ldResultW=0xDEADBEEF.
REQ-029 Store aluResultM=0x40, op2M=0x1234, ack first BUSY cycle -> mem_we=1, mem_wdata=0x1234, one mem_req cycle, validW=1 two cycles after presentation.
REQ-030 Load aluResultM=0x102 -> mem_req never asserted, stallM=0, next cycle validW=1, excW=1, isWbW=0.
REQ-031 Reset asserted mid-BUSY (mem_ack=0) -> mem_req=0 same cycle, validW=0, state IDLE; spurious mem_ack afterward ignored.
